// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Opcodes, FSM state type and signed-overflow helper for alu_seq.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Subtraction overflows like an add of the inverted B sign.
    function automatic logic signed_add_ovf(input logic a_msb, input logic b_msb,
                                            input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_iter.sv
// ============================================================================
// Module  : alu_seq_iter
// Brief   : Radix-2 signed multiply / restoring divide, one step per cycle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_seq_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             exception
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             div_ovf_q, div_ovf_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;

    logic [WIDTH-1:0]   mag_a, mag_b_in;
    logic [WIDTH:0]     add_sum, sub_diff;
    logic [WIDTH-1:0]   hi_nx, lo_nx;
    logic [2*WIDTH-1:0] prod, prod_signed;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quot_signed;

    always_comb begin
        mag_a    = op_a[WIDTH-1] ? -op_a : op_a;
        mag_b_in = op_b[WIDTH-1] ? -op_b : op_b;

        // hi holds the partial product (MUL) or partial remainder (DIV).
        add_sum  = {1'b0, hi_q} + {1'b0, mag_b_q};
        sub_diff = {hi_q, lo_q[WIDTH-1]} - {1'b0, mag_b_q};
        if (is_div_q) begin
            if (!sub_diff[WIDTH]) begin
                hi_nx = sub_diff[WIDTH-1:0];
                lo_nx = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_nx, lo_nx} = {add_sum, lo_q[WIDTH-1:1]};
        end else begin
            {hi_nx, lo_nx} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end

        prod        = {hi_nx, lo_nx};
        prod_signed = neg_q ? -prod : prod;
        prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
        quot_signed = neg_q ? -lo_nx : lo_nx;

        done      = busy_q && (cnt_q == LAST);
        result    = '0;
        overflow  = 1'b0;
        exception = 1'b0;
        if (is_div_q) begin
            if (div_zero_q) begin
                exception = 1'b1;
            end else begin
                result   = quot_signed;
                overflow = div_ovf_q;
            end
        end else begin
            result   = prod_signed[WIDTH-1:0];
            overflow = !((&prod_top) || !(|prod_top));
        end
    end

    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        div_ovf_d  = div_ovf_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mag_b_d    = mag_b_q;
        if (start) begin
            busy_d     = 1'b1;
            cnt_d      = '0;
            is_div_d   = is_div;
            neg_d      = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            div_ovf_d  = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
            div_zero_d = (op_b == '0);
            hi_d       = '0;
            lo_d       = mag_a;
            mag_b_d    = mag_b_in;
        end else if (busy_q) begin
            hi_d   = hi_nx;
            lo_d   = lo_nx;
            cnt_d  = cnt_q + CW'(1);
            busy_d = !done;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            div_ovf_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mag_b_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            div_ovf_q  <= div_ovf_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mag_b_q    <= mag_b_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : Handshaked registered ALU with iterative signed MUL/DIV.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception
);
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

    logic             accept, is_iter_op, iter_start;
    logic             iter_done, iter_ovf, iter_exc;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] sum, diff, single_res;
    logic             single_ovf, reserved;
    logic [WIDTH-1:0] flag_a, flag_b, flag_diff;
    logic             flag_ne, flag_lt;

    assign in_ready   = reset_n && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_iter_op = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);
    assign iter_start = accept && is_iter_op;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (iter_start),
        .is_div    (ctrl_ALUopcode == OP_DIV),
        .op_a      (data_operandA),
        .op_b      (data_operandB),
        .done      (iter_done),
        .result    (iter_result),
        .overflow  (iter_ovf),
        .exception (iter_exc)
    );

    always_comb begin
        sum        = data_operandA + data_operandB;
        diff       = data_operandA - data_operandB;
        single_res = '0;
        single_ovf = 1'b0;
        reserved   = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                single_res = sum;
                single_ovf = signed_add_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1],
                                            sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                single_res = diff;
                single_ovf = signed_add_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1],
                                            diff[WIDTH-1], 1'b1);
            end
            OP_AND: single_res = data_operandA & data_operandB;
            OP_OR:  single_res = data_operandA | data_operandB;
            OP_SLL: single_res = data_operandA << ctrl_shiftamt;
            OP_SRA: single_res = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
            OP_MUL, OP_DIV: single_res = '0;
            default: reserved = 1'b1;
        endcase

        // Comparison flags come from live inputs at accept, captured operands at MUL/DIV completion.
        flag_a    = (state_q == IDLE) ? data_operandA : a_q;
        flag_b    = (state_q == IDLE) ? data_operandB : b_q;
        flag_diff = flag_a - flag_b;
        flag_ne   = (flag_a != flag_b);
        flag_lt   = (flag_a[WIDTH-1] & ~flag_b[WIDTH-1])
                  | (~(flag_a[WIDTH-1] ^ flag_b[WIDTH-1]) & flag_diff[WIDTH-1]);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ne_d        = ne_q;
        lt_d        = lt_q;
        ovf_d       = ovf_q;
        exc_d       = exc_q;
        a_d         = a_q;
        b_d         = b_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d = data_operandA;
                    b_d = data_operandB;
                    if (is_iter_op) begin
                        state_d     = ITER;
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = single_res;
                        ne_d        = flag_ne && !reserved;
                        lt_d        = flag_lt && !reserved;
                        ovf_d       = single_ovf;
                        exc_d       = 1'b0;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ITER: begin
                if (iter_done) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = iter_result;
                    ne_d        = flag_ne;
                    lt_d        = flag_lt;
                    ovf_d       = iter_ovf;
                    exc_d       = iter_exc;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ne_q        <= 1'b0;
            lt_q        <= 1'b0;
            ovf_q       <= 1'b0;
            exc_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ne_q        <= ne_d;
            lt_q        <= lt_d;
            ovf_q       <= ovf_d;
            exc_q       <= exc_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign data_result = result_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;
    assign exception   = exc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module  : tb_alu_seq
// Brief   : Directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;
    logic        isNotEqual, isLessThan, overflow, exception;

    logic        v8, rdy8, ov8, ordy8;
    logic [7:0]  a8, b8, res8;
    logic [4:0]  op8;
    logic [2:0]  amt8;
    logic        ne8, lt8, ovf8, exc8;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .out_valid(out_valid), .out_ready(out_ready), .data_result(data_result),
        .isNotEqual(isNotEqual), .isLessThan(isLessThan), .overflow(overflow),
        .exception(exception)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(rdy8),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_ALUopcode(op8), .ctrl_shiftamt(amt8),
        .out_valid(ov8), .out_ready(ordy8), .data_result(res8),
        .isNotEqual(ne8), .isLessThan(lt8), .overflow(ovf8), .exception(exc8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] amt);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = amt;
        in_valid       = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data_operandA = '0; data_operandB = '0; ctrl_ALUopcode = '0; ctrl_shiftamt = '0;
        v8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; op8 = '0; amt8 = '0;
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_result", {32'd0, data_result}, 64'd0);
        chk("rst_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // ADD overflow: latency 1
        issue(5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_result", {32'd0, data_result}, 64'h8000_0000);
        chk("add_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'b1010);

        issue(5'b00001, 32'd5, 32'd7, 5'd0);
        chk("sub_result", {32'd0, data_result}, 64'hFFFF_FFFE);
        chk("sub_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'b1100);

        // MIN - 1 overflows yet MIN < 1 still holds
        issue(5'b00001, 32'h8000_0000, 32'd1, 5'd0);
        chk("subovf_result", {32'd0, data_result}, 64'h7FFF_FFFF);
        chk("subovf_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'b1110);

        issue(5'b00101, 32'h8000_0000, 32'd0, 5'd4);
        chk("sra_result", {32'd0, data_result}, 64'hF800_0000);
        issue(5'b00100, 32'h0000_1234, 32'd0, 5'd0);
        chk("sll0_result", {32'd0, data_result}, 64'h0000_1234);
        issue(5'b00100, 32'h0000_1234, 32'd0, 5'd4);
        chk("sll4_result", {32'd0, data_result}, 64'h0001_2340);
        issue(5'b01000, 32'd3, 32'd3, 5'd0);
        chk("rsv_result", {32'd0, data_result}, 64'd0);
        chk("rsv_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);

        issue(5'b00110, 32'hFFFF_FFFD, 32'd7, 5'd0);
        chk("mul_iter_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mul_iter_out_valid", {63'd0, out_valid}, 64'd0);
        wait_valid(lat);
        chk("mul_latency", 64'(lat), 64'd32);
        chk("mul_result", {32'd0, data_result}, 64'hFFFF_FFEB);
        chk("mul_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'b1100);

        issue(5'b00110, 32'h0001_0000, 32'h0001_0000, 5'd0);
        wait_valid(lat);
        chk("mulovf_result", {32'd0, data_result}, 64'd0);
        chk("mulovf_ovf", {63'd0, overflow}, 64'd1);

        issue(5'b00111, 32'hFFFF_FFF9, 32'd2, 5'd0);
        wait_valid(lat);
        chk("div_latency", 64'(lat), 64'd32);
        chk("div_result", {32'd0, data_result}, 64'hFFFF_FFFD);
        chk("div_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'b1100);

        issue(5'b00111, 32'd5, 32'd0, 5'd0);
        wait_valid(lat);
        chk("div0_latency", 64'(lat), 64'd32);
        chk("div0_result", {32'd0, data_result}, 64'd0);
        chk("div0_exc_ovf", {62'd0, exception, overflow}, 64'b10);

        issue(5'b00111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        wait_valid(lat);
        chk("divovf_result", {32'd0, data_result}, 64'h8000_0000);
        chk("divovf_exc_ovf", {62'd0, exception, overflow}, 64'b01);

        // Reset while DIV is at cnt=5
        issue(5'b00111, 32'd100, 32'd3, 5'd0);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mrst_result", {32'd0, data_result}, 64'd0);
        chk("mrst_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);
        reset_n = 1'b1;
        tick();
        chk("mrst_rel_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) tick();
        chk("mrst_no_stale_result", {63'd0, out_valid}, 64'd0);

        // Backpressure then same-edge accept
        out_ready = 1'b0;
        issue(5'b00000, 32'd2, 32'd3, 5'd0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {30'd0, out_valid, in_ready, data_result}, {30'd0, 2'b10, 32'd5});
            tick();
        end
        out_ready = 1'b1;
        issue(5'b00010, 32'h0000_00F0, 32'h0000_003C, 5'd0);
        chk("bp_same_edge", {31'd0, out_valid, data_result}, {31'd0, 1'b1, 32'h30});

        // Stream three ops, one per edge
        data_operandA = 32'hFF00_FF00; data_operandB = 32'h0F0F_0F0F;
        in_valid = 1'b1; ctrl_ALUopcode = 5'b00010;
        tick();
        chk("b2b_and", {31'd0, out_valid, data_result}, {31'd0, 1'b1, 32'h0F00_0F00});
        ctrl_ALUopcode = 5'b00011;
        tick();
        chk("b2b_or", {31'd0, out_valid, data_result}, {31'd0, 1'b1, 32'hFF0F_FF0F});
        ctrl_ALUopcode = 5'b00000;
        tick();
        chk("b2b_add", {30'd0, out_valid, overflow, data_result}, {30'd0, 2'b10, 32'h0E10_0E0F});
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", {63'd0, out_valid}, 64'd0);

        // WIDTH=8 instance: MUL 0x7F*2
        a8 = 8'h7F; b8 = 8'h02; op8 = 5'b00110; v8 = 1'b1;
        chk("w8_in_ready", {63'd0, rdy8}, 64'd1);
        tick();
        v8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            tick();
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'd8);
        chk("w8_result", {56'd0, res8}, 64'hFE);
        chk("w8_ovf_exc", {62'd0, ovf8, exc8}, 64'b10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
